// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce_edge input conditioner.
package debounce_pkg;

    typedef enum logic [1:0] {
        IdleLo = 2'b00,
        WaitHi = 2'b01,
        IdleHi = 2'b10,
        WaitLo = 2'b11
    } deb_state_e;

    localparam int unsigned DefStableCycles = 1000;
    localparam int unsigned DefCntW         = 16;

    function automatic logic is_wait(input deb_state_e st);
        return (st == WaitHi) || (st == WaitLo);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; synchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/debounce_edge.sv
// Debounces a raw level into a clean level plus one-cycle rise/fall pulses.
// Define DEBOUNCE_SYNC_EN to insert a 2-flop synchronizer ahead of the sample register.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DefStableCycles,
    parameter int unsigned CNT_W         = DefCntW
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q,
    output logic o_qb,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic       s_raw;
    logic       s_d, s_q;
    deb_state_e state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic       level_d, level_q;
    logic       rise_d, rise_q;
    logic       fall_d, fall_q;
    logic       busy_d, busy_q;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff u_sync_2ff (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (i_d),
        .q_o     (s_raw)
    );
`else
    assign s_raw = i_d;
`endif

    always_comb begin
        s_d     = s_raw;
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IdleLo: begin
                level_d = 1'b0;
                if (s_q) begin
                    state_d = WaitHi;
                    cnt_d   = CntOne;
                end else begin
                    cnt_d = '0;
                end
            end
            WaitHi: begin
                if (!s_q) begin
                    state_d = IdleLo;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = IdleHi;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            IdleHi: begin
                level_d = 1'b1;
                if (!s_q) begin
                    state_d = WaitLo;
                    cnt_d   = CntOne;
                end else begin
                    cnt_d = '0;
                end
            end
            WaitLo: begin
                if (s_q) begin
                    state_d = IdleHi;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = IdleLo;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = IdleLo;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
        // Busy is registered alongside the state it describes.
        busy_d = is_wait(state_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_q     <= 1'b0;
            state_q <= IdleLo;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            s_q     <= s_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign o_q    = level_q;
    assign o_qb   = ~level_q;
    assign o_rise = rise_q;
    assign o_fall = fall_q;
    assign o_busy = busy_q;

endmodule
